// File: rtl/ball_move_sched.sv
// Step scheduler for Ball: converts held direction buttons into hold-delay/auto-repeat
// step pulses and, when no button is active, accepts queued moves from an auto requester.
module ball_move_sched #(
  parameter bit          SIMULATE     = 1'b0,
  parameter int unsigned DELAY_TICKS  = 50_000_000,
  parameter int unsigned REPEAT_TICKS = 10_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] btn_req,
  input  logic       auto_req_valid,
  input  logic [1:0] auto_req_dir,
  output logic       auto_req_ready,
  output logic       x_increment,
  output logic       x_decrement,
  output logic       y_increment,
  output logic       y_decrement,
  output logic       busy,
  output logic [1:0] last_dir,
  output logic [7:0] step_count
);

  // Reload values are period-1 so pulses land exactly DELAY/REPEAT edges apart;
  // they saturate when the period does not fit the counter.
  localparam longint unsigned CNT_MAX    = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned DELAY_EFF  = SIMULATE ? 64'd8 : 64'(DELAY_TICKS);
  localparam longint unsigned REPEAT_EFF = SIMULATE ? 64'd4 : 64'(REPEAT_TICKS);
  localparam longint unsigned DELAY_L    = (DELAY_EFF - 64'd1 > CNT_MAX) ? CNT_MAX : DELAY_EFF - 64'd1;
  localparam longint unsigned REPEAT_L   = (REPEAT_EFF - 64'd1 > CNT_MAX) ? CNT_MAX : REPEAT_EFF - 64'd1;
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(DELAY_L);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_L);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_AUTO_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       hold_q, hold_d;
  logic [3:0]       pulse_q;
  logic [3:0]       btn_eff;
  logic             sel_valid;
  logic [1:0]       sel_dir;
  logic             fire, press;
  logic [1:0]       fire_dir;

  // Opposing buttons on one axis cancel that axis, then fixed priority picks a direction.
  always_comb begin
    btn_eff   = {btn_req[3:2] & ~{2{&btn_req[3:2]}}, btn_req[1:0] & ~{2{&btn_req[1:0]}}};
    sel_valid = |btn_eff;
    sel_dir   = 2'd0;
    if (btn_eff[0])      sel_dir = 2'd0;
    else if (btn_eff[1]) sel_dir = 2'd1;
    else if (btn_eff[2]) sel_dir = 2'd2;
    else if (btn_eff[3]) sel_dir = 2'd3;
  end

  assign auto_req_ready = enable & (state_q == S_IDLE) & ~sel_valid;
  assign busy           = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    fire     = 1'b0;
    fire_dir = hold_q;
    press    = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_valid) begin
            press = 1'b1;
          end else if (auto_req_valid) begin
            fire     = 1'b1;
            fire_dir = auto_req_dir;
            cnt_d    = REPEAT_LOAD;
            state_d  = S_AUTO_GAP;
          end
        end
        S_AUTO_GAP: begin
          if (sel_valid)           press   = 1'b1;
          else if (cnt_q == '0)    state_d = S_IDLE;
          else                     cnt_d   = cnt_q - CNT_W'(1);
        end
        S_DELAY, S_REPEAT: begin
          if (!sel_valid) begin
            state_d = S_IDLE;
          end else if (sel_dir != hold_q) begin
            press = 1'b1;
          end else if (cnt_q == '0) begin
            fire    = 1'b1;
            cnt_d   = REPEAT_LOAD;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
      // A new press (from idle, a gap, or a direction change) steps at once and restarts the hold delay.
      if (press) begin
        fire     = 1'b1;
        fire_dir = sel_dir;
        hold_d   = sel_dir;
        cnt_d    = DELAY_LOAD;
        state_d  = S_DELAY;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hold_q     <= 2'd0;
      pulse_q    <= 4'd0;
      last_dir   <= 2'd0;
      step_count <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pulse_q <= 4'd0;
      if (fire) begin
        pulse_q    <= 4'd1 << fire_dir;
        last_dir   <= fire_dir;
        step_count <= step_count + 8'd1;
      end
    end
  end

  assign x_increment = pulse_q[0];
  assign x_decrement = pulse_q[1];
  assign y_increment = pulse_q[2];
  assign y_decrement = pulse_q[3];

endmodule

// File: doc/ball_move_sched.md
Name: ball_move_sched

Overview:
Sequences step commands into the Ball position datapath. It turns held, debounced direction buttons into single-cycle increment/decrement pulses: one immediate step, then an initial hold delay, then auto-repeat. When no button is active, it also accepts queued moves from an automatic requester (demo/maze logic) over a valid/ready handshake. It sits between the debounce block and Ball, and guarantees at most one step pulse per clock.

Parameters:
SIMULATE, 0, 1 selects short timing: DELAY=8 and REPEAT=4 cycles.
DELAY_TICKS, 50_000_000, cycles from the first step to the second step of a hold (500 ms at 100 MHz).
REPEAT_TICKS, 10_000_000, cycles between auto-repeat steps; also the minimum gap after an auto step.
CNT_W, 26, width of the timing counter.

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous reset, active-low
enable  in  1  step generation allowed
btn_req  in  4  held button levels {y_dec,y_inc,x_dec,x_inc} (bit0=x_inc)
auto_req_valid  in  1  auto requester has a move
auto_req_dir  in  2  0=x_inc 1=x_dec 2=y_inc 3=y_dec
auto_req_ready  out  1  move accepted this cycle when valid&ready
x_increment  out  1  one-cycle step pulse to Ball
x_decrement  out  1  one-cycle step pulse
y_increment  out  1  one-cycle step pulse
y_decrement  out  1  one-cycle step pulse
busy  out  1  state != IDLE
last_dir  out  2  direction of the most recent pulse
step_count  out  8  pulses issued, wraps 255->0

Behaviour:
- Reset (async, low): state IDLE; all pulse outputs, busy, last_dir, step_count and counter = 0.
- Button selection, combinational:
  - x_inc&x_dec both set cancels the X axis; y_inc&y_dec both set cancels the Y axis.
  - Among the remaining bits, fixed priority x_inc > x_dec > y_inc > y_dec gives sel_valid/sel_dir.
- Step pulse outputs are registered. Exactly one is high for one cycle per step. step_count increments and last_dir updates on the same edge the pulse is registered.
- States: IDLE, DELAY, REPEAT, AUTO_GAP.
- IDLE:
  - enable & sel_valid: register a pulse for sel_dir (visible the next cycle), hold_dir=sel_dir, counter=DELAY-1, go to DELAY.
  - Otherwise, enable & auto_req_valid: register a pulse for auto_req_dir, counter=REPEAT-1, go to AUTO_GAP.
- DELAY/REPEAT:
  - sel_valid=0: go to IDLE with no pulse.
  - sel_dir != hold_dir: treat as a new press (pulse, reload DELAY-1, state DELAY).
  - Otherwise decrement the counter. At counter==0, register a pulse for hold_dir, reload REPEAT-1, state REPEAT.
  - Net timing: pulses at t, t+DELAY, then every REPEAT cycles.
- AUTO_GAP:
  - Counter decrements; at 0 go to IDLE.
  - sel_valid preempts the gap: behave exactly as IDLE with a button.
  - Auto requests are not accepted during the gap.
- auto_req_ready (combinational) = enable & state==IDLE & !sel_valid. A transfer occurs on valid&ready; the requester must hold valid/dir stable until the transfer.
- enable=0: from any state go to IDLE on the next edge. No new pulses are registered; ready=0. A pulse already registered still completes its single cycle.
- Counter width CNT_W; loads saturate at the parameter value minus 1. DELAY and REPEAT must be >= 2.

Test Plan:
- SIMULATE=1, hold btn_req=0001 for 30 cycles from edge 0 -> x_increment high at cycles 1, 9, 13, 17, 21, 25, 29; step_count=7; last_dir=0; busy=1 until the button is released, then 0 one cycle later.
- Tap btn_req=0100 for 3 cycles -> exactly one y_increment pulse; step_count=1; state returns to IDLE with no further pulses.
- btn_req=0011 (x_inc+x_dec) -> no pulses and auto_req_ready=1; btn_req=1011 -> y_decrement pulses only, last_dir=3.
- No buttons, auto_req_valid=1 with dir=2 held continuously -> ready pulses at cycles 0, 5, 10, …; one y_increment per accept. Pressing btn x_dec during a gap -> x_decrement on the next cycle, and ready stays 0 while the button is held.
- Hold x_inc until REPEAT, then assert reset low mid-count -> all outputs 0 immediately (before the next edge), step_count=0. Release reset with x_inc still held -> first pulse one cycle after the first active edge, next pulse DELAY cycles later.
- Hold x_inc, drop enable for 10 cycles -> no pulses, busy=0, ready=0. Re-raise enable -> immediate pulse, then DELAY timing restarts.
